// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers: the common
// three-state sequencing used by the adder and by later serial engines.
package serial_add_ctrl_pkg;

   // Controller state encoding, shared by every serial controller.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_add_ctrl_pkg

// File: rtl/fulladd.sv
// Single-bit full adder cell; the only arithmetic element of the serial engine.
module fulladd (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   // Purely combinational sum and carry of three input bits.
   always_comb begin
      sum   = a ^ b ^ c_in;
      c_out = (a & b) | (a & c_in) | (b & c_in);
   end

endmodule : fulladd

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Operands are latched on an accepted
// start, streamed LSB-first through one fulladd cell over W cycles with a
// registered carry, and the W-bit result plus carry and signed overflow are
// published together on the completing edge, accompanied by a done pulse.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow
);

   state_t             state, state_nxt;
   logic [W-1:0]       sa, sb;       // operand shift registers, LSB consumed first
   logic [W-1:0]       res_sr;       // sum bits enter at the MSB end
   logic               carry_ff;     // carry between successive bit slices
   logic [CNT_W-1:0]   bit_cnt;
   logic               fa_sum, fa_cout;
   logic               accept;
   logic               last_bit;

   fulladd u_fulladd (
      .a     (sa[0]),
      .b     (sb[0]),
      .c_in  (carry_ff),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   // A new op is only taken while idle or in the done cycle; starts during RUN are dropped.
   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_bit = (state == ST_RUN) && (bit_cnt == CNT_W'(W - 1));
   assign busy     = (state == ST_RUN);
   assign done     = (state == ST_DONE);

   // Next-state logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start)    state_nxt = ST_RUN;
         ST_RUN:  if (last_bit) state_nxt = ST_DONE;
         ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, serial datapath and result publication.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state     <= ST_IDLE;
         sa        <= '0;
         sb        <= '0;
         res_sr    <= '0;
         carry_ff  <= 1'b0;
         bit_cnt   <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            sa       <= a;
            sb       <= sub ? ~b : b;
            carry_ff <= sub;
            bit_cnt  <= '0;
         end else if (state == ST_RUN) begin
            sa       <= sa >> 1;
            sb       <= sb >> 1;
            res_sr   <= {fa_sum, res_sr[W-1:1]};
            carry_ff <= fa_cout;
            bit_cnt  <= bit_cnt + CNT_W'(1);
         end
         if (last_bit) begin
            // carry_ff here is the carry into the MSB slice; XOR with its carry out gives signed overflow.
            result    <= {fa_sum, res_sr[W-1:1]};
            carry_out <= fa_cout;
            overflow  <= carry_ff ^ fa_cout;
         end
      end
   end

endmodule : serial_add_ctrl
